// File: rtl/mem_wb_stage.sv
// Memory stage plus MEM/WB register: resolves branches, runs the data-memory req/ack
// handshake with a timeout abort, and raises mem_stall while an access is in flight.
module mem_wb_stage #(
   parameter int XLEN    = 64,
   parameter int RADDR_W = 5,
   parameter int TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [RADDR_W-1:0] EX_MEM_Rd,
   input  logic [XLEN-1:0]    EX_MEM_ALU,
   input  logic [XLEN-1:0]    EX_MEM_MUX_FB,
   input  logic [XLEN-1:0]    EX_MEM_Adder,
   input  logic               EX_MEM_Zero,
   input  logic               EX_MEM_Great,
   input  logic               EX_MEM_BranchEq,
   input  logic               EX_MEM_BranchGt,
   input  logic               EX_MEM_MemRead,
   input  logic               EX_MEM_MemWrite,
   input  logic               EX_MEM_RegWrite,
   input  logic               EX_MEM_MemtoReg,
   output logic               dmem_req,
   output logic               dmem_we,
   output logic [XLEN-1:0]    dmem_addr,
   output logic [XLEN-1:0]    dmem_wdata,
   input  logic [XLEN-1:0]    dmem_rdata,
   input  logic               dmem_ack,
   output logic               PCSrc,
   output logic [XLEN-1:0]    Branch_Target,
   output logic               mem_stall,
   output logic               mem_err,
   output logic [RADDR_W-1:0] MEM_WB_Rd,
   output logic [XLEN-1:0]    MEM_WB_ALU,
   output logic [XLEN-1:0]    MEM_WB_ReadData,
   output logic               MEM_WB_RegWrite,
   output logic               MEM_WB_MemtoReg
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_count;

   logic w_memOp;
   logic w_timeout;
   logic w_wbRegWrite;

   assign w_memOp      = EX_MEM_MemRead | EX_MEM_MemWrite;
   assign w_timeout    = (r_count == CW'(TIMEOUT - 1));
   assign w_wbRegWrite = EX_MEM_RegWrite & (EX_MEM_Rd != '0);

   assign PCSrc         = (EX_MEM_BranchEq & EX_MEM_Zero) | (EX_MEM_BranchGt & EX_MEM_Great);
   assign Branch_Target = EX_MEM_Adder;

   // Stall drops on the ack/abort cycle so upstream advances in step with the MEM/WB update.
   always_comb begin
      mem_stall = 1'b0;
      if (r_state == IDLE) begin
         mem_stall = w_memOp;
      end else begin
         mem_stall = ~(dmem_ack | w_timeout);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state         <= IDLE;
         r_count         <= '0;
         dmem_req        <= 1'b0;
         dmem_we         <= 1'b0;
         dmem_addr       <= '0;
         dmem_wdata      <= '0;
         mem_err         <= 1'b0;
         MEM_WB_Rd       <= '0;
         MEM_WB_ALU      <= '0;
         MEM_WB_ReadData <= '0;
         MEM_WB_RegWrite <= 1'b0;
         MEM_WB_MemtoReg <= 1'b0;
      end else begin
         MEM_WB_Rd       <= '0;
         MEM_WB_ALU      <= '0;
         MEM_WB_ReadData <= '0;
         MEM_WB_RegWrite <= 1'b0;
         MEM_WB_MemtoReg <= 1'b0;
         if (r_state == IDLE) begin
            if (w_memOp) begin
               r_state    <= ACCESS;
               r_count    <= '0;
               dmem_req   <= 1'b1;
               dmem_we    <= EX_MEM_MemWrite;
               dmem_addr  <= EX_MEM_ALU;
               dmem_wdata <= EX_MEM_MUX_FB;
            end else begin
               MEM_WB_Rd       <= EX_MEM_Rd;
               MEM_WB_ALU      <= EX_MEM_ALU;
               MEM_WB_RegWrite <= w_wbRegWrite;
               MEM_WB_MemtoReg <= EX_MEM_MemtoReg;
            end
         end else begin
            r_count <= r_count + CW'(1);
            if (dmem_ack) begin
               r_state         <= IDLE;
               dmem_req        <= 1'b0;
               MEM_WB_Rd       <= EX_MEM_Rd;
               MEM_WB_ALU      <= EX_MEM_ALU;
               MEM_WB_ReadData <= dmem_we ? '0 : dmem_rdata;
               MEM_WB_RegWrite <= w_wbRegWrite;
               MEM_WB_MemtoReg <= EX_MEM_MemtoReg;
            end else if (w_timeout) begin
               r_state  <= IDLE;
               dmem_req <= 1'b0;
               mem_err  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage: per-cycle expectations from a transaction-level
// model are queued by the stimulus and checked by an independent monitor.
module tb_mem_wb_stage;

   localparam int XLEN    = 64;
   localparam int RADDR_W = 5;
   localparam int TIMEOUT = 16;

   logic               clk;
   logic               reset;
   logic [RADDR_W-1:0] EX_MEM_Rd;
   logic [XLEN-1:0]    EX_MEM_ALU, EX_MEM_MUX_FB, EX_MEM_Adder;
   logic               EX_MEM_Zero, EX_MEM_Great, EX_MEM_BranchEq, EX_MEM_BranchGt;
   logic               EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_RegWrite, EX_MEM_MemtoReg;
   logic               dmem_req, dmem_we;
   logic [XLEN-1:0]    dmem_addr, dmem_wdata, dmem_rdata;
   logic               dmem_ack;
   logic               PCSrc;
   logic [XLEN-1:0]    Branch_Target;
   logic               mem_stall, mem_err;
   logic [RADDR_W-1:0] MEM_WB_Rd;
   logic [XLEN-1:0]    MEM_WB_ALU, MEM_WB_ReadData;
   logic               MEM_WB_RegWrite, MEM_WB_MemtoReg;

   mem_wb_stage #(.XLEN(XLEN), .RADDR_W(RADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .EX_MEM_Rd(EX_MEM_Rd), .EX_MEM_ALU(EX_MEM_ALU), .EX_MEM_MUX_FB(EX_MEM_MUX_FB),
      .EX_MEM_Adder(EX_MEM_Adder), .EX_MEM_Zero(EX_MEM_Zero), .EX_MEM_Great(EX_MEM_Great),
      .EX_MEM_BranchEq(EX_MEM_BranchEq), .EX_MEM_BranchGt(EX_MEM_BranchGt),
      .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
      .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_MemtoReg(EX_MEM_MemtoReg),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .PCSrc(PCSrc), .Branch_Target(Branch_Target), .mem_stall(mem_stall), .mem_err(mem_err),
      .MEM_WB_Rd(MEM_WB_Rd), .MEM_WB_ALU(MEM_WB_ALU), .MEM_WB_ReadData(MEM_WB_ReadData),
      .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_MemtoReg(MEM_WB_MemtoReg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [RADDR_W-1:0] rd;
      logic [XLEN-1:0]    alu, fb, adder, rdata;
      logic               zero, great, beq, bgt, mr, mw, rw, m2r, idleAck;
      int                 ackDelay;
   } txn_t;

   typedef struct {
      logic               stall, req, chkBus, we, pcsrc, err, full, rw, m2r;
      logic [XLEN-1:0]    addr, wdata, tgt, alu, rdata;
      logic [RADDR_W-1:0] rd;
   } cycExp_t;

   cycExp_t expQ[$];
   int vectors = 0;
   int miscompares = 0;

   // Architectural view of the MEM/WB register and error flag as the model sees them.
   logic [RADDR_W-1:0] mRd;
   logic [XLEN-1:0]    mAlu, mData;
   logic               mRw, mM2r, mFull, mErr;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic checkBit(input string name, input logic act, input logic exp);
      checkOutput(name, 64'(act), 64'(exp));
   endtask

   function automatic txn_t blankTxn();
      txn_t t;
      t.rd = '0; t.alu = '0; t.fb = '0; t.adder = '0; t.rdata = '0;
      t.zero = 0; t.great = 0; t.beq = 0; t.bgt = 0; t.mr = 0; t.mw = 0;
      t.rw = 0; t.m2r = 0; t.idleAck = 0; t.ackDelay = 0;
      return t;
   endfunction

   function automatic logic [XLEN-1:0] rand64();
      return {$urandom(), $urandom()};
   endfunction

   function automatic txn_t randTxn();
      txn_t t;
      int   sel;
      t = blankTxn();
      t.rd       = ($urandom_range(0, 7) == 0) ? '0 : 5'($urandom_range(1, 31));
      t.alu      = rand64();
      t.fb       = rand64();
      t.adder    = rand64();
      t.rdata    = rand64();
      t.zero     = 1'($urandom_range(0, 1));
      t.great    = 1'($urandom_range(0, 1));
      t.beq      = 1'($urandom_range(0, 1));
      t.bgt      = 1'($urandom_range(0, 1));
      t.rw       = 1'($urandom_range(0, 1));
      t.m2r      = 1'($urandom_range(0, 1));
      t.idleAck  = ($urandom_range(0, 3) == 0);
      t.ackDelay = $urandom_range(0, 5);
      sel = $urandom_range(0, 3);
      if (sel == 2) t.mr = 1'b1;
      if (sel == 3) begin
         t.mw = 1'b1;
         t.mr = 1'($urandom_range(0, 1));
      end
      return t;
   endfunction

   task automatic driveInputs(input txn_t t);
      EX_MEM_Rd = t.rd; EX_MEM_ALU = t.alu; EX_MEM_MUX_FB = t.fb; EX_MEM_Adder = t.adder;
      EX_MEM_Zero = t.zero; EX_MEM_Great = t.great;
      EX_MEM_BranchEq = t.beq; EX_MEM_BranchGt = t.bgt;
      EX_MEM_MemRead = t.mr; EX_MEM_MemWrite = t.mw;
      EX_MEM_RegWrite = t.rw; EX_MEM_MemtoReg = t.m2r;
   endtask

   task automatic pushCycle(input txn_t t, input logic stall, input logic req, input logic chkBus);
      cycExp_t e;
      e.stall = stall; e.req = req; e.chkBus = chkBus;
      e.we = t.mw; e.addr = t.alu; e.wdata = t.fb;
      e.pcsrc = (t.beq & t.zero) | (t.bgt & t.great);
      e.tgt = t.adder;
      e.err = mErr; e.full = mFull;
      e.rd = mRd; e.rw = mRw; e.m2r = mM2r; e.alu = mAlu; e.rdata = mData;
      expQ.push_back(e);
   endtask

   task automatic modelWriteback(input txn_t t, input logic [XLEN-1:0] data);
      mRd = t.rd; mRw = t.rw && (t.rd != 0); mM2r = t.m2r; mAlu = t.alu; mData = data; mFull = 1;
   endtask

   task automatic modelBubble();
      mRd = '0; mRw = 0; mM2r = 0; mFull = 0;
   endtask

   task automatic modelReset();
      mRd = '0; mRw = 0; mM2r = 0; mAlu = '0; mData = '0; mFull = 1; mErr = 0;
   endtask

   // Called at the start of a cycle; returns at the start of the cycle after the instruction retires.
   task automatic applyStimulus(input txn_t t);
      int   last;
      logic ackNow;
      driveInputs(t);
      dmem_ack   = t.idleAck;
      dmem_rdata = rand64();
      if (!(t.mr | t.mw)) begin
         pushCycle(t, 1'b0, 1'b0, 1'b0);
         modelWriteback(t, '0);
         @(posedge clk); #1;
      end else begin
         pushCycle(t, 1'b1, 1'b0, 1'b0);
         modelBubble();
         @(posedge clk); #1;
         last = (t.ackDelay < TIMEOUT) ? t.ackDelay : TIMEOUT - 1;
         for (int k = 0; k <= last; k++) begin
            ackNow     = (k == t.ackDelay);
            dmem_ack   = ackNow;
            dmem_rdata = ackNow ? t.rdata : rand64();
            pushCycle(t, (k == last) ? 1'b0 : 1'b1, 1'b1, 1'b1);
            if (k < last) modelBubble();
            else if (ackNow) modelWriteback(t, t.mw ? '0 : t.rdata);
            else begin
               modelBubble();
               mErr = 1;
            end
            @(posedge clk); #1;
         end
      end
   endtask

   // Monitor: one expectation per cycle, sampled on the falling edge.
   initial begin
      cycExp_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkBit("mem_stall", mem_stall, e.stall);
            checkBit("dmem_req", dmem_req, e.req);
            if (e.chkBus) begin
               checkBit("dmem_we", dmem_we, e.we);
               checkOutput("dmem_addr", dmem_addr, e.addr);
               checkOutput("dmem_wdata", dmem_wdata, e.wdata);
            end
            checkBit("PCSrc", PCSrc, e.pcsrc);
            checkOutput("Branch_Target", Branch_Target, e.tgt);
            checkBit("mem_err", mem_err, e.err);
            checkOutput("MEM_WB_Rd", 64'(MEM_WB_Rd), 64'(e.rd));
            checkBit("MEM_WB_RegWrite", MEM_WB_RegWrite, e.rw);
            checkBit("MEM_WB_MemtoReg", MEM_WB_MemtoReg, e.m2r);
            if (e.full) begin
               checkOutput("MEM_WB_ALU", MEM_WB_ALU, e.alu);
               checkOutput("MEM_WB_ReadData", MEM_WB_ReadData, e.rdata);
            end
         end
      end
   end

   task automatic checkAllZero(input string tag);
      checkBit({tag, "_dmem_req"}, dmem_req, 1'b0);
      checkBit({tag, "_dmem_we"}, dmem_we, 1'b0);
      checkOutput({tag, "_dmem_addr"}, dmem_addr, '0);
      checkOutput({tag, "_dmem_wdata"}, dmem_wdata, '0);
      checkBit({tag, "_mem_err"}, mem_err, 1'b0);
      checkOutput({tag, "_MEM_WB_Rd"}, 64'(MEM_WB_Rd), '0);
      checkOutput({tag, "_MEM_WB_ALU"}, MEM_WB_ALU, '0);
      checkOutput({tag, "_MEM_WB_ReadData"}, MEM_WB_ReadData, '0);
      checkBit({tag, "_MEM_WB_RegWrite"}, MEM_WB_RegWrite, 1'b0);
      checkBit({tag, "_MEM_WB_MemtoReg"}, MEM_WB_MemtoReg, 1'b0);
   endtask

   initial begin
      txn_t t;
      reset = 1'b1;
      driveInputs(blankTxn());
      dmem_ack = 1'b0; dmem_rdata = '0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkAllZero("reset");
      reset = 1'b0;

      // Plain ALU result, no memory op.
      t = blankTxn(); t.alu = 64'h1234; t.rd = 5'd5; t.rw = 1'b1;
      applyStimulus(t);

      // Load acknowledged after three waiting cycles.
      t = blankTxn(); t.alu = 64'h40; t.rd = 5'd7; t.rw = 1'b1; t.m2r = 1'b1; t.mr = 1'b1;
      t.ackDelay = 3; t.rdata = 64'hDEADBEEF;
      applyStimulus(t);

      // Store acknowledged on the first access cycle.
      t = blankTxn(); t.alu = 64'h80; t.fb = 64'hAA; t.mw = 1'b1; t.ackDelay = 0;
      applyStimulus(t);

      // Branch resolution: taken on equal, not taken on greater with Great clear.
      t = blankTxn(); t.beq = 1'b1; t.zero = 1'b1; t.adder = 64'h100;
      applyStimulus(t);
      t = blankTxn(); t.bgt = 1'b1; t.great = 1'b0; t.adder = 64'h200;
      applyStimulus(t);

      for (int i = 0; i < 80; i++) applyStimulus(randTxn());

      // Load that never completes, then a stray ack while idle.
      t = blankTxn(); t.alu = 64'h500; t.rd = 5'd3; t.rw = 1'b1; t.m2r = 1'b1; t.mr = 1'b1;
      t.ackDelay = TIMEOUT + 4;
      applyStimulus(t);
      t = blankTxn(); t.alu = 64'h600; t.rd = 5'd4; t.rw = 1'b1; t.idleAck = 1'b1;
      applyStimulus(t);
      for (int i = 0; i < 10; i++) applyStimulus(randTxn());

      // Asynchronous reset in the middle of an access.
      t = blankTxn(); t.alu = 64'h300; t.rd = 5'd9; t.rw = 1'b1; t.m2r = 1'b1; t.mr = 1'b1;
      driveInputs(t);
      dmem_ack = 1'b0;
      pushCycle(t, 1'b1, 1'b0, 1'b0);
      modelBubble();
      @(posedge clk); #1;
      pushCycle(t, 1'b1, 1'b1, 1'b1);
      modelBubble();
      @(negedge clk); #2;
      reset = 1'b1;
      #1;
      checkAllZero("async_reset");
      modelReset();
      t = blankTxn(); t.alu = 64'h55; t.rd = 5'd3; t.rw = 1'b1; t.idleAck = 1'b1;
      driveInputs(t);
      dmem_ack = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      applyStimulus(t);

      // Writes to x0 are suppressed.
      t = blankTxn(); t.alu = 64'h77; t.rd = 5'd0; t.rw = 1'b1;
      applyStimulus(t);
      for (int i = 0; i < 20; i++) applyStimulus(randTxn());
      applyStimulus(blankTxn());

      for (int i = 0; i < 20 && expQ.size() > 0; i++) @(negedge clk);
      #1;
      if (expQ.size() != 0) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
